// File: rtl/eth_loopback_composed_line_merger_timing_adapter.sv
`default_nettype none
// ============================================================================
// eth_loopback_composed_line_merger_timing_adapter
// Avalon-ST ready-latency adapter (latency L in, latency 0 out) with skid FIFO.
// Revision: 1.0
// ============================================================================
module eth_loopback_composed_line_merger_timing_adapter #(
    parameter int DATA_WIDTH       = 72,
    parameter int IN_READY_LATENCY = 1,
    parameter int DEPTH            = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  protocol_err
);
    localparam int L  = IN_READY_LATENCY;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(DEPTH + L + 1);

    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [L-1:0]          ready_hist_q, ready_hist_d;
    logic                  err_q, err_d;
    logic                  en_q;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  grant_now;
    logic                  wr_en;
    logic                  rd_en;
    logic [SW-1:0]         inflight;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Stored beats plus every grant whose beat may still arrive.
    always_comb begin
        inflight = SW'(count_q);
        for (int i = 0; i < L; i++) begin
            inflight = inflight + SW'(ready_hist_q[i]);
        end
    end

    assign in_ready  = en_q && (inflight < SW'(DEPTH));
    assign grant_now = ready_hist_q[L-1];
    assign wr_en     = in_valid && grant_now;
    assign out_valid = (count_q != '0);
    assign rd_en     = out_valid && out_ready;
    assign out_data  = mem_q[rd_ptr_q];
    assign protocol_err = err_q;

    generate
        if (L == 1) begin : g_hist_single
            assign ready_hist_d = in_ready;
        end else begin : g_hist_shift
            assign ready_hist_d = {ready_hist_q[L-2:0], in_ready};
        end
    endgenerate

    always_comb begin
        wr_ptr_d = wr_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = rd_en ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CW'(wr_en) - CW'(rd_en);
        err_d    = err_q || (in_valid && !grant_now);
    end

    // en_q holds in_ready low while reset is asserted and releases it cleanly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            ready_hist_q <= '0;
            err_q        <= 1'b0;
            en_q         <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            ready_hist_q <= ready_hist_d;
            err_q        <= err_d;
            en_q         <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end
endmodule
`default_nettype wire
